stepper_phase_driver: RTL and testbench
=======================================

# stepper_phase_driver

Step-timing and coil-sequencing stage that sits directly downstream of the speed control stage. It consumes the 32-bit `counter_limit` period word and counts clock cycles against it, emitting one step every `counter_limit` cycles. On each step it advances the stepper coil pattern in the commanded direction and keeps a signed position count. It drives the four coil outputs that go to the motor driver pins.

## Interface
- `CNT_W`, 32: width of `counter_limit` and of the internal period counter.
- `MIN_LIMIT`, 1000: smallest accepted period; any smaller sampled limit, including 0, is clamped up to it.
- `POS_W`, 16: width of the `position` output.

Ports:
- `clk`  in  1  system clock.
- `resetb`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; 1 = stepping, 0 = stopped and coils de-energised.
- `dir`  in  1  direction; 1 = forward (phase index +1), 0 = reverse (phase index −1).
- `counter_limit`  in  CNT_W  step period in clk cycles, from the speed control stage.
- `coils`  out  4  coil drive pattern {A, B, C, D}.
- `step_pulse`  out  1  one-cycle pulse on every step.
- `position`  out  POS_W  signed two's-complement step count.
- `running`  out  1  high while stepping.

## Operation
- Reset values: `coils`=0000, `step_pulse`=0, `position`=0, `running`=0, phase index 0, counter 0, latched limit = `MIN_LIMIT`.
- State machine, two states:
  - IDLE (`running`=0).
  - RUN (`running`=1).
- IDLE → RUN when `enable` is sampled 1. In that same edge:
  - counter ← 0.
  - latched limit ← clamp(`counter_limit`).
  - `coils` ← pattern[phase]. The motor re-energises on the held phase with no step.
- In RUN, the counter increments every cycle. Terminal count is counter == latched limit − 1. At terminal count, in the same edge:
  - counter ← 0.
  - phase ← phase ± 1 mod N, sign taken from `dir` sampled on this cycle.
  - `coils` ← pattern[new phase].
  - `step_pulse` ← 1.
  - `position` ← `position` ± 1, wrapping modulo 2^POS_W.
  - latched limit ← clamp(`counter_limit`).
- `counter_limit` changes mid-period are ignored until the next terminal count. This keeps the period glitch-free.
- RUN → IDLE when `enable` is sampled 0. In that edge:
  - `coils` ← 0000, counter ← 0, `step_pulse` ← 0.
  - Phase index and `position` are retained.
  - Stop takes priority over a coincident terminal count: no step, no position change.
- `dir` may change at any time. It only takes effect at a step edge.
- Full-step sequence, N=4, index 0..3: 1100, 0110, 0011, 1001.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `enable` 0→1 sampled at edge k:
  - `running` and `coils` valid after edge k.
  - First `step_pulse` goes high after edge k+L, where L = latched limit.
- Steady state: one step every L cycles. `step_pulse` is high for exactly 1 cycle and coincides with the new `coils` value.
- `enable` 1→0 sampled at edge k: `coils`=0000 and `running`=0 after edge k.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first edge after `resetb` deasserts behaves as IDLE.

## Configuration
- `STEPPER_HALF_STEP_EN` defined:
  - Half-step sequence, N=8, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Each step moves one index. `position` counts half-steps.
  - Reset phase index 0, pattern 1000.
- Undefined: full-step sequence only, N=4. The phase register is 2 bits.

## Test plan
Benches use `MIN_LIMIT`=2 unless stated otherwise.
- Reset/start: reset, then `enable`=1, `dir`=1, `counter_limit`=4.
  - `coils`=1100 one edge after enable.
  - `step_pulse` every 4 cycles.
  - `coils` go 0110, 0011, 1001, 1100.
  - `position` goes 1, 2, 3, 4.
- Reverse and wrap:
  - From phase 0 with `dir`=0, first step gives `coils`=1001 and `position`=−1 (0xFFFF).
  - Separately, preload `position`=0x7FFF by stepping, with `dir`=1: next step gives 0x8000.
- Limit change/clamp:
  - Change `counter_limit` 4→6 mid-period: the current period stays 4 and the next period is 6.
  - `counter_limit`=0 gives a period of 2.
- Stop collision: deassert `enable` on the terminal-count cycle.
  - No `step_pulse`, `position` unchanged, `coils`=0000.
  - Re-enable restores the held phase pattern.
- Async reset mid-run: pulse `resetb` low mid-period. All outputs are 0 immediately and phase restarts at index 0.
- Half-step build (`STEPPER_HALF_STEP_EN`), `counter_limit`=3, `dir`=1:
  - `coils` 1000, 1100, 0100, …, 1001, 1000.
  - 8 pulses, `position`=8.

Source files
------------

// File: rtl/stepper_phase_driver.sv
// Step-period counter and coil sequencer: one coil-pattern step every latched period, with signed position.
// Define STEPPER_HALF_STEP_EN for the 8-entry half-step sequence; the default build is 4-entry full-step.
module stepper_phase_driver #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MIN_LIMIT = 1000,
  parameter int unsigned POS_W     = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  input  logic             dir,
  input  logic [CNT_W-1:0] counter_limit,
  output logic [3:0]       coils,
  output logic             step_pulse,
  output logic [POS_W-1:0] position,
  output logic             running
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned PH_W = 3;
`else
  localparam int unsigned PH_W = 2;
`endif

  localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] r_limit;
  logic [PH_W-1:0]  r_phase;
  logic [3:0]       r_coils;
  logic             r_step_pulse;
  logic [POS_W-1:0] r_position;
  logic             r_running;

  logic [CNT_W-1:0] w_limit_clamped;
  logic             w_terminal;
  logic [PH_W-1:0]  w_phase_next;
  logic [POS_W-1:0] w_position_next;

  // Phase index to coil pattern {A, B, C, D}.
  function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] idx);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

  // Phase register width equals log2(N), so the +/-1 wraps modulo N for free.
  assign w_limit_clamped = (counter_limit < MIN_L) ? MIN_L : counter_limit;
  assign w_terminal      = (r_counter == (r_limit - CNT_ONE));
  assign w_phase_next    = dir ? (r_phase + PH_ONE) : (r_phase - PH_ONE);
  assign w_position_next = dir ? (r_position + POS_ONE) : (r_position - POS_ONE);

  // NOTE: every state register below uses non-blocking assignment so all of
  // them update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_IDLE;
      r_counter    <= '0;
      r_limit      <= MIN_L;
      r_phase      <= '0;
      r_coils      <= 4'b0000;
      r_step_pulse <= 1'b0;
      r_position   <= '0;
      r_running    <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_counter <= '0;
            r_limit   <= w_limit_clamped;
            r_coils   <= phase_pattern(r_phase);
          end
        end
        S_RUN: begin
          // Stop wins over a coincident terminal count: no step is taken.
          if (!enable) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_counter <= '0;
            r_coils   <= 4'b0000;
          end else if (w_terminal) begin
            r_counter    <= '0;
            r_limit      <= w_limit_clamped;
            r_phase      <= w_phase_next;
            r_coils      <= phase_pattern(w_phase_next);
            r_step_pulse <= 1'b1;
            r_position   <= w_position_next;
          end else begin
            r_counter <= r_counter + CNT_ONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_counter <= '0;
          r_coils   <= 4'b0000;
        end
      endcase
    end
  end

  assign coils      = r_coils;
  assign step_pulse = r_step_pulse;
  assign position   = r_position;
  assign running    = r_running;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Directed bench for stepper_phase_driver (MIN_LIMIT=2); a second instance with an 8-bit position
// exercises the signed wrap from max positive to min negative in a short run.
module tb_stepper_phase_driver;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic        dir = 1'b1;
  logic [31:0] counter_limit = 32'd4;

  logic [3:0]  coils, coils_w;
  logic        step_pulse, pulse_w;
  logic        running, running_w;
  logic [15:0] position;
  logic [7:0]  position_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stepper_phase_driver #(.CNT_W(32), .MIN_LIMIT(2), .POS_W(16)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dir(dir), .counter_limit(counter_limit),
    .coils(coils), .step_pulse(step_pulse), .position(position), .running(running)
  );

  stepper_phase_driver #(.CNT_W(32), .MIN_LIMIT(2), .POS_W(8)) dut_w (
    .clk(clk), .resetb(resetb), .enable(enable), .dir(dir), .counter_limit(counter_limit),
    .coils(coils_w), .step_pulse(pulse_w), .position(position_w), .running(running_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one full period of len cycles; the pulse must appear only on the last edge.
  task automatic run_period(input int len, input logic [3:0] exp_coils,
                            input logic [15:0] exp_pos, input string tag);
    int early;
    early = 0;
    for (int i = 0; i < len - 1; i++) begin
      tick();
      if (step_pulse !== 1'b0) early++;
    end
    check({tag, "_early_pulses"}, 32'(early), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(step_pulse), 32'd1);
    check({tag, "_coils"}, 32'(coils), 32'(exp_coils));
    check({tag, "_pos"}, 32'(position), 32'(exp_pos));
  endtask

`ifdef STEPPER_HALF_STEP_EN
  logic [3:0] hs_pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};
`endif

  initial begin
    repeat (2) tick();
    check("reset_coils", 32'(coils), 32'd0);
    check("reset_pulse", 32'(step_pulse), 32'd0);
    check("reset_pos", 32'(position), 32'd0);
    check("reset_running", 32'(running), 32'd0);

`ifdef STEPPER_HALF_STEP_EN
    resetb = 1'b1; enable = 1'b1; dir = 1'b1; counter_limit = 32'd3;
    tick();
    check("hs_start_coils", 32'(coils), 32'(4'b1000));
    for (int s = 1; s <= 8; s++) run_period(3, hs_pat[s % 8], 16'(s), "hs_step");
`else
    resetb = 1'b1; enable = 1'b1; dir = 1'b1; counter_limit = 32'd4;
    tick();
    check("start_running", 32'(running), 32'd1);
    check("start_coils", 32'(coils), 32'(4'b1100));
    check("start_pulse", 32'(step_pulse), 32'd0);

    run_period(4, 4'b0110, 16'd1, "fwd1");
    run_period(4, 4'b0011, 16'd2, "fwd2");
    run_period(4, 4'b1001, 16'd3, "fwd3");
    run_period(4, 4'b1100, 16'd4, "fwd4");

    // Limit changed one cycle into a period: this period stays 4, next one is 6.
    tick();
    counter_limit = 32'd6;
    tick();
    tick();
    check("chg_nopulse", 32'(step_pulse), 32'd0);
    tick();
    check("chg_pulse", 32'(step_pulse), 32'd1);
    check("chg_coils", 32'(coils), 32'(4'b0110));
    check("chg_pos", 32'(position), 32'd5);
    run_period(6, 4'b0011, 16'd6, "per6");

    counter_limit = 32'd0;
    run_period(6, 4'b1001, 16'd7, "per6b");

    // Latched limit is now clamp(0)=2; the next edge is the terminal-count edge.
    tick();
    check("prestop_pulse", 32'(step_pulse), 32'd0);
    enable = 1'b0;
    tick();
    check("stop_pulse", 32'(step_pulse), 32'd0);
    check("stop_pos", 32'(position), 32'd7);
    check("stop_coils", 32'(coils), 32'd0);
    check("stop_running", 32'(running), 32'd0);
    tick();
    check("idle_coils", 32'(coils), 32'd0);
    enable = 1'b1;
    tick();
    check("reen_coils", 32'(coils), 32'(4'b1001));
    check("reen_running", 32'(running), 32'd1);
    counter_limit = 32'd4;
    run_period(2, 4'b1100, 16'd8, "clamp2");

    dir = 1'b0;
    run_period(4, 4'b1001, 16'd7, "rev1");

    tick();
    tick();
    resetb = 1'b0;
    #2;
    check("arst_coils", 32'(coils), 32'd0);
    check("arst_pulse", 32'(step_pulse), 32'd0);
    check("arst_pos", 32'(position), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    resetb = 1'b1;
    tick();
    check("arst_restart_coils", 32'(coils), 32'(4'b1100));
    run_period(4, 4'b1001, 16'hFFFF, "rev_wrap");
    check("rev_wrap_pos_w", 32'(position_w), 32'h0000_00FF);

    dir = 1'b1;
    counter_limit = 32'd0;
    run_period(4, 4'b1100, 16'd0, "fwd_back");
    for (int s = 0; s < 127; s++) repeat (2) tick();
    check("pre_cross_pos", 32'(position), 32'h0000_007F);
    check("pre_cross_pos_w", 32'(position_w), 32'h0000_007F);
    run_period(2, 4'b1100, 16'h0080, "pos_cross");
    check("pos_cross_w", 32'(position_w), 32'h0000_0080);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
